// File: rtl/ycr1_wbb_pkg.sv
// Shared types and constants for the wishbone burst splitter.
package ycr1_wbb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    WAITB = 3'd3,
    DRAIN = 3'd4
  } wbb_state_e;

  localparam int unsigned WBB_BW      = 4;
  // Each beat advances by one full bus word, i.e. one byte per byte lane.
  localparam int unsigned WBB_ADR_INC = WBB_BW;

  function automatic logic [31:0] wbb_bl_norm(input logic [31:0] bl);
    return (bl == 32'd0) ? 32'd1 : bl;
  endfunction

endpackage

// File: rtl/ycr1_wbb_burst_split.sv
// Splits an upstream wishbone burst into single-beat classic accesses,
// returning one ack per beat and flagging the final beat with lack.
//
// state | meaning
// IDLE  | waiting for cyc & stb & bry to start a burst
// REQ   | downstream strobe held until ack or err
// RESP  | one-cycle upstream ack; advance address and beat count
// WAITB | waiting for bry before issuing the next beat
// DRAIN | burst done; wait for upstream stb to fall
module ycr1_wbb_burst_split
  import ycr1_wbb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = WBB_BW,
  parameter int BL = 10
) (
  input  logic          wbs_clk_i,
  input  logic          wbs_rst_n,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic [AW-1:0] wbs_adr_i,
  input  logic          wbs_we_i,
  input  logic [DW-1:0] wbs_dat_i,
  input  logic [BW-1:0] wbs_sel_i,
  input  logic [BL-1:0] wbs_bl_i,
  input  logic          wbs_bry_i,
  output logic [DW-1:0] wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_lack_o,
  output logic          wbs_err_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic          wbm_we_o,
  output logic [DW-1:0] wbm_dat_o,
  output logic [BW-1:0] wbm_sel_o,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i
);

  localparam logic [AW-1:0] ADR_INC = AW'(WBB_ADR_INC);

  wbb_state_e    state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          we_q, we_d;
  logic [BW-1:0] sel_q, sel_d;
  logic [BL-1:0] rem_q, rem_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          ack_q, ack_d;
  logic          lack_q, lack_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    ack_d   = 1'b0;
    lack_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && wbs_bry_i) begin
          adr_d   = wbs_adr_i;
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          rem_d   = BL'(wbb_bl_norm(32'(wbs_bl_i)));
          wdat_d  = wbs_dat_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (wbm_ack_i || wbm_err_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = wbm_err_i;
          lack_d  = (rem_q == BL'(1));
          rdat_d  = we_q ? '0 : wbm_dat_i;
          state_d = RESP;
        end
      end
      RESP: begin
        rem_d   = rem_q - BL'(1);
        adr_d   = adr_q + ADR_INC;
        state_d = (rem_q == BL'(1)) ? DRAIN : WAITB;
      end
      WAITB: begin
        // Upstream has already popped the acked beat, so wbs_dat_i is the next one.
        if (wbs_bry_i) begin
          wdat_d  = wbs_dat_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (!wbs_stb_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wbs_clk_i) begin
    if (!wbs_rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rem_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      ack_q   <= 1'b0;
      lack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
      lack_q  <= lack_d;
      err_q   <= err_d;
    end
  end

  assign wbs_dat_o  = rdat_q;
  assign wbs_ack_o  = ack_q;
  assign wbs_lack_o = lack_q;
  assign wbs_err_o  = err_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_we_o   = we_q;
  assign wbm_dat_o  = wdat_q;
  assign wbm_sel_o  = sel_q;

endmodule

// File: tb/tb_ycr1_wbb_burst_split.sv
// Bench for the burst splitter: directed burst table, a few hand-written
// sequences, and randomized bursts checked against a per-beat reference model.
module tb_ycr1_wbb_burst_split;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int BL = 10;

  logic          clk = 1'b0;
  logic          wbs_rst_n;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_bry_i;
  logic [AW-1:0] wbs_adr_i;
  logic [DW-1:0] wbs_dat_i;
  logic [BW-1:0] wbs_sel_i;
  logic [BL-1:0] wbs_bl_i;
  logic [DW-1:0] wbs_dat_o;
  logic          wbs_ack_o, wbs_lack_o, wbs_err_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [BW-1:0] wbm_sel_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i, wbm_err_i;

  always #5 clk = ~clk;

  ycr1_wbb_burst_split #(.AW(AW), .DW(DW), .BW(BW), .BL(BL)) dut (
    .wbs_clk_i(clk),          .wbs_rst_n(wbs_rst_n),
    .wbs_cyc_i(wbs_cyc_i),    .wbs_stb_i(wbs_stb_i),
    .wbs_adr_i(wbs_adr_i),    .wbs_we_i(wbs_we_i),
    .wbs_dat_i(wbs_dat_i),    .wbs_sel_i(wbs_sel_i),
    .wbs_bl_i(wbs_bl_i),      .wbs_bry_i(wbs_bry_i),
    .wbs_dat_o(wbs_dat_o),    .wbs_ack_o(wbs_ack_o),
    .wbs_lack_o(wbs_lack_o),  .wbs_err_o(wbs_err_o),
    .wbm_cyc_o(wbm_cyc_o),    .wbm_stb_o(wbm_stb_o),
    .wbm_adr_o(wbm_adr_o),    .wbm_we_o(wbm_we_o),
    .wbm_dat_o(wbm_dat_o),    .wbm_sel_o(wbm_sel_o),
    .wbm_dat_i(wbm_dat_i),    .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i)
  );

  // err_beat / stall_beat / rst_beat are 1-based beat numbers; 0 disables.
  typedef struct {
    logic [31:0] adr;
    bit          we;
    int          bl;
    logic [3:0]  sel;
    logic [31:0] seed;
    int          err_beat;
    int          wait_cyc;
    int          stall_beat;
    int          stall_len;
    int          drain_hold;
    bit          drop_stb;
    bit          spur;
    int          rst_beat;
    int          exp_beats;
    int          exp_errs;
  } burst_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic int m_beats(input burst_t b);
    return (b.bl == 0) ? 1 : b.bl;
  endfunction

  function automatic logic [31:0] m_adr(input burst_t b, input int i);
    return b.adr + 32'(i * BW);
  endfunction

  function automatic logic [31:0] m_wdat(input burst_t b, input int i);
    return b.seed ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] m_rdat(input burst_t b, input int i);
    return b.seed + 32'h11 * 32'(i + 1);
  endfunction

  task automatic run_burst(input burst_t b);
    int cyc = 0, beats_ds = 0, acks_us = 0, lacks = 0, errs = 0;
    int slave_wait = 0, slave_ack_cyc = -1, exp_stb_cyc = 1;
    int stall_left = 0, post = 0;
    bit stb_prev = 0, done = 0, in_post = 0, stable = 1;
    logic [31:0] f_adr, f_dat;
    logic [3:0]  f_sel;
    logic        f_we;

    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_bry_i = 1'b1;
    wbs_adr_i = b.adr; wbs_we_i = b.we; wbs_sel_i = b.sel;
    wbs_bl_i  = BL'(b.bl); wbs_dat_i = m_wdat(b, 0);
    f_adr = '0; f_dat = '0; f_sel = '0; f_we = 1'b0;

    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!wbs_rst_n) begin
        check("rst_outs_zero", 64'(|{wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o, wbm_cyc_o,
                                     wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o}), 0);
        check("rst_acks_before", acks_us, b.exp_beats);
        check("rst_no_lack", lacks, 0);
        wbs_rst_n = 1'b1;
        repeat (4) begin
          @(negedge clk);
          check("rst_quiet", {wbm_stb_o, wbs_ack_o, wbs_lack_o}, 0);
        end
        done = 1;
      end else begin
        if (wbm_stb_o) begin
          if (!stb_prev) begin
            check("stb_time", cyc, exp_stb_cyc);
            check("ds_adr", wbm_adr_o, m_adr(b, beats_ds));
            check("ds_we", wbm_we_o, b.we);
            check("ds_sel", wbm_sel_o, b.sel);
            check("ds_cyc", wbm_cyc_o, 1);
            if (b.we) check("ds_wdat", wbm_dat_o, m_wdat(b, beats_ds));
            f_adr = wbm_adr_o; f_dat = wbm_dat_o; f_sel = wbm_sel_o; f_we = wbm_we_o;
            stable = 1; slave_wait = 0;
            beats_ds++;
            if (beats_ds == b.rst_beat) begin
              wbs_rst_n = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            end
          end else begin
            stable &= (wbm_adr_o == f_adr) && (wbm_dat_o == f_dat) && (wbm_sel_o == f_sel)
                      && (wbm_we_o == f_we) && wbm_cyc_o;
          end
          if (wbs_rst_n && slave_wait == b.wait_cyc) begin
            check("ds_stable", stable, 1);
            wbm_ack_i = (beats_ds != b.err_beat);
            wbm_err_i = (beats_ds == b.err_beat);
            wbm_dat_i = m_rdat(b, beats_ds - 1);
            slave_ack_cyc = cyc;
          end else begin
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
          end
          slave_wait++;
        end else begin
          wbm_ack_i = b.spur && ($urandom_range(0, 2) == 0);
          wbm_err_i = b.spur && ($urandom_range(0, 3) == 0);
          wbm_dat_i = $urandom;
        end
        stb_prev = wbm_stb_o;

        if (wbs_ack_o) begin
          acks_us++;
          check("ack_time", cyc, slave_ack_cyc + 1);
          check("us_dat", wbs_dat_o, b.we ? 32'h0 : m_rdat(b, acks_us - 1));
          check("us_err", wbs_err_o, acks_us == b.err_beat);
          check("us_lack", wbs_lack_o, acks_us == m_beats(b));
          errs  += int'(wbs_err_o);
          lacks += int'(wbs_lack_o);
          wbs_dat_i = m_wdat(b, acks_us);
          if (acks_us == b.stall_beat && b.stall_len > 0) begin
            wbs_bry_i   = 1'b0;
            stall_left  = b.stall_len;
            exp_stb_cyc = cyc + ((b.stall_len + 1 > 2) ? b.stall_len + 1 : 2);
          end else begin
            exp_stb_cyc = cyc + 2;
          end
          if (b.drop_stb) begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
          end
          if (wbs_lack_o) begin
            in_post = 1; post = 0; exp_stb_cyc = -1;
          end
        end else begin
          if (wbs_lack_o || wbs_err_o) check("pulse_without_ack", {wbs_lack_o, wbs_err_o}, 0);
          if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) wbs_bry_i = 1'b1;
          end
        end

        if (in_post) begin
          if (post == b.drain_hold) begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
          end
          if (post == b.drain_hold + 2) done = 1;
          post++;
        end
      end
    end

    check("burst_done_in_budget", done, 1);
    if (b.rst_beat == 0) begin
      check("beat_count", acks_us, b.exp_beats);
      check("lack_count", lacks, 1);
      check("err_count", errs, b.exp_errs);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_bry_i = 1'b1;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
  endtask

  burst_t vec[8];
  burst_t rb;

  initial begin
    wbs_rst_n = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_bry_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_bl_i = '0;
    wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;

    //           adr           we bl sel   seed          err wt stb sln dh drp spr rst exb exe
    vec[0] = '{32'h0000_0100, 1, 1, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0};
    vec[1] = '{32'h0000_1000, 0, 4, 4'hF, 32'h0000_0000, 0, 0, 0, 0, 1, 0, 0, 0, 4, 0};
    vec[2] = '{32'h0000_2000, 1, 3, 4'h3, 32'h1234_5678, 0, 0, 1, 5, 0, 0, 0, 0, 3, 0};
    vec[3] = '{32'h0000_3000, 0, 3, 4'hF, 32'h0000_0500, 2, 1, 0, 0, 1, 0, 0, 0, 3, 1};
    vec[4] = '{32'h0000_0040, 1, 0, 4'hC, 32'hCAFE_0000, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    vec[5] = '{32'hFFFF_FFFC, 0, 2, 4'hF, 32'h0000_7000, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0};
    vec[6] = '{32'h0000_5000, 0, 4, 4'hF, 32'h0000_9000, 0, 2, 0, 0, 0, 0, 0, 2, 1, 0};
    vec[7] = '{32'h0000_6000, 1, 2, 4'h5, 32'h5A5A_0000, 0, 1, 0, 0, 0, 1, 0, 0, 2, 0};

    repeat (3) @(negedge clk);
    check("reset_outs_zero", 64'(|{wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o, wbm_cyc_o,
                                   wbm_stb_o, wbm_adr_o, wbm_we_o, wbm_dat_o, wbm_sel_o}), 0);
    wbs_rst_n = 1'b1;
    @(negedge clk);

    // Incomplete trigger conditions must not start a burst.
    wbs_bl_i = BL'(1); wbs_adr_i = 32'h0000_0A00;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_bry_i = 1'b0;
    repeat (3) begin @(negedge clk); check("no_trig_without_bry", wbm_stb_o, 0); end
    wbs_stb_i = 1'b0; wbs_bry_i = 1'b1;
    repeat (3) begin @(negedge clk); check("no_trig_without_stb", wbm_stb_o, 0); end
    wbs_cyc_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_burst(vec[i]);

    for (int n = 0; n < 30; n++) begin
      rb.adr        = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3))
                                                 : ($urandom & 32'hFFFF_FFFC);
      rb.we         = 1'($urandom_range(0, 1));
      rb.bl         = $urandom_range(0, 6);
      rb.sel        = 4'($urandom);
      rb.seed       = $urandom;
      rb.err_beat   = $urandom_range(0, 7);
      rb.wait_cyc   = $urandom_range(0, 3);
      rb.stall_beat = $urandom_range(1, 6);
      rb.stall_len  = $urandom_range(0, 4);
      rb.drain_hold = $urandom_range(0, 3);
      rb.drop_stb   = 1'($urandom_range(0, 1));
      rb.spur       = 1'b1;
      rb.rst_beat   = 0;
      rb.exp_beats  = m_beats(rb);
      rb.exp_errs   = (rb.err_beat >= 1 && rb.err_beat <= rb.exp_beats) ? 1 : 0;
      run_burst(rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
